// File: rtl/biquad_banda_if.sv
// Sample/coefficient bus of the band biquad: strobe and operands in; filtered sample
// plus the leer/escribir strobes toward the downstream band register out.
interface biquad_banda_if #(parameter int cant_bits = 25);
  logic                        inicio;
  logic signed [cant_bits-1:0] x_in;
  logic signed [cant_bits-1:0] b0;
  logic signed [cant_bits-1:0] b1;
  logic signed [cant_bits-1:0] b2;
  logic signed [cant_bits-1:0] a1;
  logic signed [cant_bits-1:0] a2;
  logic signed [cant_bits-1:0] y_out;
  logic                        leer;
  logic                        escribir;
  logic                        ocupado;

  modport master (
    output inicio, x_in, b0, b1, b2, a1, a2,
    input  y_out, leer, escribir, ocupado
  );

  modport slave (
    input  inicio, x_in, b0, b1, b2, a1, a2,
    output y_out, leer, escribir, ocupado
  );
endinterface

// File: rtl/biquad_banda.sv
// Sequential biquad section: one shared multiplier, 5-cycle MAC, 10 cycles per sample.
// Output clamp instead of wrap when BIQUAD_SATURACION_EN is defined.
module biquad_banda #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 16
) (
  input  logic           clk,
  input  logic           reset,
  biquad_banda_if.slave  bus
);
  localparam int PW = 2 * cant_bits;
  localparam int SW = PW - frac_bits;
  localparam int AW = SW + 3;

  typedef enum logic [2:0] {ESPERA, CARGA, MAC, SATURA, LEER, ESCRIBIR} estado_t;

  estado_t estado_q, estado_d;
  logic [2:0] idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [cant_bits-1:0] x_q, b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [cant_bits-1:0] x1_q, x2_q, y1_q, y2_q, y_out_q;
  logic signed [cant_bits-1:0] coef, dato, y_sat;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] prod_sh;
  logic signed [AW-1:0] termino;
  logic leer_c, escribir_c, ocupado_c;

  always_comb begin
    coef = b0_q;
    dato = x_q;
    case (idx_q)
      3'd0:    begin coef = b0_q; dato = x_q;  end
      3'd1:    begin coef = b1_q; dato = x1_q; end
      3'd2:    begin coef = b2_q; dato = x2_q; end
      3'd3:    begin coef = a1_q; dato = y1_q; end
      default: begin coef = a2_q; dato = y2_q; end
    endcase
    prod    = $signed({{cant_bits{coef[cant_bits-1]}}, coef})
            * $signed({{cant_bits{dato[cant_bits-1]}}, dato});
    // Arithmetic shift gives floor rounding for negative products.
    prod_sh = SW'(prod >>> frac_bits);
    termino = {{3{prod_sh[SW-1]}}, prod_sh};
  end

  always_comb begin
`ifdef BIQUAD_SATURACION_EN
    if ((acc_q[AW-1:cant_bits-1] == '0) || (acc_q[AW-1:cant_bits-1] == '1))
      y_sat = acc_q[cant_bits-1:0];
    else if (acc_q[AW-1])
      y_sat = {1'b1, {(cant_bits-1){1'b0}}};
    else
      y_sat = {1'b0, {(cant_bits-1){1'b1}}};
`else
    y_sat = acc_q[cant_bits-1:0];
`endif
  end

  always_comb begin
    estado_d   = estado_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    leer_c     = 1'b0;
    escribir_c = 1'b0;
    ocupado_c  = 1'b1;
    case (estado_q)
      ESPERA: begin
        ocupado_c = 1'b0;
        if (bus.inicio) estado_d = CARGA;
      end
      CARGA: begin
        acc_d    = '0;
        idx_d    = 3'd0;
        estado_d = MAC;
      end
      MAC: begin
        acc_d = (idx_q < 3'd3) ? acc_q + termino : acc_q - termino;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd4) estado_d = SATURA;
      end
      SATURA:   estado_d = LEER;
      LEER: begin
        leer_c   = 1'b1;
        estado_d = ESCRIBIR;
      end
      ESCRIBIR: begin
        escribir_c = 1'b1;
        estado_d   = ESPERA;
      end
      default:  estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ESPERA;
      idx_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      y_out_q  <= '0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      if (estado_q == ESPERA && bus.inicio) begin
        x_q  <= bus.x_in;
        b0_q <= bus.b0;
        b1_q <= bus.b1;
        b2_q <= bus.b2;
        a1_q <= bus.a1;
        a2_q <= bus.a2;
      end
      // The converted (possibly clamped) value is what feeds back as y1.
      if (estado_q == SATURA) begin
        y_out_q <= y_sat;
        x2_q    <= x1_q;
        x1_q    <= x_q;
        y2_q    <= y1_q;
        y1_q    <= y_sat;
      end
    end
  end

  assign bus.y_out    = y_out_q;
  assign bus.leer     = leer_c;
  assign bus.escribir = escribir_c;
  assign bus.ocupado  = ocupado_c;
endmodule

// File: tb/tb_biquad_banda.sv
// Directed bench for biquad_banda: timing, filter arithmetic, saturation, busy and reset behaviour.
module tb_biquad_banda;
  localparam int CB = 25;
  localparam int FB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  biquad_banda_if #(.cant_bits(CB)) bus ();
  biquad_banda #(.cant_bits(CB), .frac_bits(FB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full pass; observes cycles 1..10 after the accepting edge.
  task automatic do_pass(input int x, input int c0, input int c1, input int c2,
                         input int d1, input int d2, input int poke,
                         output logic signed [CB-1:0] y, output int lat, output int esc_at,
                         output int nl, output int ne, output int both,
                         output logic occ1, output logic occ10);
    @(negedge clk);
    bus.x_in = CB'(x); bus.b0 = CB'(c0); bus.b1 = CB'(c1); bus.b2 = CB'(c2);
    bus.a1 = CB'(d1); bus.a2 = CB'(d2);
    bus.inicio = 1'b1;
    @(posedge clk);
    y = '0; lat = -1; esc_at = -1; nl = 0; ne = 0; both = 0; occ1 = 1'b0; occ10 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.inicio = (k == poke);
      if (k == 1) begin
        bus.x_in = CB'($urandom); bus.b0 = CB'($urandom); bus.b1 = CB'($urandom);
        bus.b2 = CB'($urandom); bus.a1 = CB'($urandom); bus.a2 = CB'($urandom);
        occ1 = bus.ocupado;
      end
      if (bus.leer) begin
        nl++;
        if (lat < 0) begin lat = k; y = bus.y_out; end
      end
      if (bus.escribir) begin
        ne++;
        if (esc_at < 0) esc_at = k;
      end
      if (bus.leer && bus.escribir) both++;
      if (k == 10) occ10 = bus.ocupado;
    end
    bus.inicio = 1'b0;
  endtask

  logic signed [CB-1:0] y;
  int lat, esc_at, nl, ne, both, strobes;
  logic occ1, occ10;

  initial begin
    reset = 1'b1;
    bus.inicio = 1'b0; bus.x_in = '0;
    bus.b0 = '0; bus.b1 = '0; bus.b2 = '0; bus.a1 = '0; bus.a2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y_out", bus.y_out, 0);
    check("rst_leer", bus.leer, 0);
    check("rst_escribir", bus.escribir, 0);
    check("rst_ocupado", bus.ocupado, 0);
    reset = 1'b0;

    // Pass-through with full timing.
    do_pass(12345, 65536, 0, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("pt_y", y, 12345);
    check("pt_leer_cycle", lat, 8);
    check("pt_escribir_cycle", esc_at, 9);
    check("pt_leer_count", nl, 1);
    check("pt_escribir_count", ne, 1);
    check("pt_strobes_overlap", both, 0);
    check("pt_ocupado_c1", occ1, 1);
    check("pt_ocupado_c10", occ10, 0);

    do_reset();
    do_pass(100, 0, 65536, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("delay_y0", y, 0);
    do_pass(200, 0, 65536, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("delay_y1", y, 100);

    do_reset();
    do_pass(1000, 65536, 0, 0, -32768, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("fb_y0", y, 1000);
    do_pass(0, 65536, 0, 0, -32768, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("fb_y1", y, 500);
    do_pass(0, 65536, 0, 0, -32768, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("fb_y2", y, 250);

    do_reset();
    do_pass(-3, 32768, 0, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("floor_neg", y, -2);
    do_pass(3, 32768, 0, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("floor_pos", y, 1);

    do_reset();
    do_pass(8388608, 262144, 0, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
`ifdef BIQUAD_SATURACION_EN
    check("sat_pos", y, 16777215);
`else
    check("wrap_pos", y, 0);
`endif
    do_pass(-8388608, 262144, 0, 0, 0, 0, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
`ifdef BIQUAD_SATURACION_EN
    check("sat_neg", y, -16777216);
`else
    check("wrap_neg", y, 0);
`endif

    // inicio while busy must be dropped, not queued.
    do_reset();
    do_pass(55, 65536, 0, 0, 0, 0, 4, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("busy_y", y, 55);
    check("busy_leer_count", nl, 1);
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.leer || bus.escribir || bus.ocupado) strobes++;
    end
    check("busy_no_queued_pass", strobes, 0);

    // Reset at cycle 5 aborts the pass.
    @(negedge clk);
    bus.x_in = CB'(999); bus.b0 = CB'(65536); bus.inicio = 1'b1;
    @(posedge clk);
    strobes = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.inicio = 1'b0;
      if (bus.leer || bus.escribir) strobes++;
      if (k == 5) begin
        check("abort_ocupado_before", bus.ocupado, 1);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    check("abort_y_out", bus.y_out, 0);
    check("abort_leer", bus.leer, 0);
    check("abort_escribir", bus.escribir, 0);
    check("abort_ocupado", bus.ocupado, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.leer || bus.escribir) strobes++;
    end
    check("abort_no_strobes", strobes, 0);

    // Every delay-line tap weighted: only a cleared delay line yields 7.
    do_pass(7, 65536, 65536, 65536, -65536, -65536, 0, y, lat, esc_at, nl, ne, both, occ1, occ10);
    check("post_reset_y", y, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/biquad_banda.md
# biquad_banda

Sequential second-order IIR (biquad) section for the band filter path. Each sample strobe runs one shared-multiplier MAC pass over the current input and the filter's two-sample delay line. The result is saturated and presented on `y_out`. The block then drives the `leer`/`escribir` strobe pair of the downstream band register: load first, transfer next cycle.

## Interface
- `cant_bits`, 25: signed sample/coefficient width, two's complement.
- `frac_bits`, 16: fractional bits of the fixed-point format. 1.0 = 2^frac_bits.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `inicio`, input, 1: sample strobe. Accepted only in ESPERA.
- `x_in`, input, cant_bits: input sample, latched on the accepted `inicio`.
- `b0`, `b1`, `b2`, `a1`, `a2`, input, cant_bits each: signed coefficients, latched on the accepted `inicio`.
- `y_out`, output, cant_bits: filtered sample. Held stable from the LEER state until the next SATURA.
- `leer`, output, 1: one-cycle load strobe to the downstream register.
- `escribir`, output, 1: one-cycle transfer strobe, the cycle after `leer`.
- `ocupado`, output, 1: high from the cycle after an accepted `inicio` through ESCRIBIR.

## Operation
- **Difference equation:** y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- **Delay line:** x1, x2, y1, y2 are internal registers.
- **States:** ESPERA → CARGA → MAC → SATURA → LEER → ESCRIBIR → ESPERA.
  - **ESPERA:** idle, `ocupado`=0. An `inicio`=1 latches `x_in` and all coefficients, then moves to CARGA.
  - **CARGA:** clears the accumulator and sets the MAC index to 0.
  - **MAC:** 5 cycles, index 0..4. Operand pairs in order: (b0,x), (b1,x1), (b2,x2), (a1,y1), (a2,y2).
    - Each cycle forms one signed product and arithmetic-shifts it right by frac_bits (floor).
    - Indices 0–2 add the shifted product to the accumulator; indices 3–4 subtract it.
  - **SATURA:** converts the accumulator to cant_bits (see Configuration) and loads `y_out`.
    - Updates the delay line: x2←x1, x1←x, y2←y1, y1←y.
  - **LEER:** `leer`=1 for this cycle only.
  - **ESCRIBIR:** `escribir`=1 for this cycle only, then return to ESPERA.
- **Widths:**
  - Product: 2·cant_bits.
  - Shifted product: 2·cant_bits − frac_bits.
  - Accumulator: shifted product width + 3 guard bits, so no internal overflow is possible.
- `leer` and `escribir` are never high together.
- **`inicio` while busy:** any `inicio` outside ESPERA is ignored and is not queued.
- **Reset:**
  - Forces ESPERA.
  - Clears `y_out`, `leer`, `escribir`, `ocupado`, the accumulator, the delay line and the latched operands, all to 0.
  - A reset mid-operation aborts the pass. No strobe is emitted for it.
- Coefficient port changes after acceptance do not affect the pass in progress.

## Timing
Cycle 0 is the edge that samples `inicio`=1 in ESPERA.
- **Cycle 1:** CARGA, `ocupado`=1.
- **Cycles 2–6:** MAC.
- **Cycle 7:** SATURA.
- **Cycle 8:** LEER. `y_out` is valid and `leer`=1.
- **Cycle 9:** ESCRIBIR, `escribir`=1.
- **Cycle 10:** ESPERA, `ocupado`=0. A new `inicio` sampled at cycle 10 is accepted.
- **Throughput:** one sample per 10 cycles.
- **Input-to-output latency:** 8 cycles from `inicio` to `leer`.
- **Back-to-back strobes:** `inicio` held high continuously produces one pass per 10 cycles.

## Configuration
- **`BIQUAD_SATURACION_EN` defined:**
  - SATURA clamps to the range [−2^(cant_bits−1), 2^(cant_bits−1)−1].
  - The clamped value is also what is written to y1.
- **Undefined:** SATURA keeps the low cant_bits of the accumulator (two's-complement wrap), with no clamp logic.

## Test plan
All values use the default parameters, so 1.0 = 65536.
- **Pass-through:** b0=65536, others 0, `inicio` with x=12345 → `y_out`=12345, `leer` at cycle 8, `escribir` at cycle 9, `ocupado` low at cycle 10.
- **Pure delay:** b1=65536, others 0, samples x=100 then x=200 → y=0, then y=100.
- **Feedback:** b0=65536, a1=−32768, samples x=1000, 0, 0 → y=1000, 500, 250.
- **Floor rounding:** b0=32768, x=−3 → y=−2. The same coefficient with x=3 → y=1.
- **Saturation:** b0=262144, x=8388608.
  - With the macro defined: y=16777215.
  - Without the macro: y=0 (wrap).
  - Repeat with x=−8388608; with the macro: y=−16777216.
- **Busy and reset:**
  - `inicio` pulsed at cycle 4 of a pass → ignored, exactly one `leer` for the pass.
  - `reset` at cycle 5 → no `leer`/`escribir`, all outputs 0 next cycle.
  - A subsequent pass-through run with x=7 returns y=7, confirming the delay line was cleared.
